// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serial bit-pattern scanner with a configurable
// 1..8-bit pattern and overlapping or non-overlapping match counting.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   cfg_we       pattern configuration write strobe (accepted in IDLE only)
//   cfg_pattern  match pattern; bit [L-1] earliest, bit [0] latest
//   cfg_len      pattern length minus one (L = cfg_len + 1)
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   start        begin a scan of frame_len bits (accepted in IDLE only)
//   frame_len    number of serial bits to scan, 0..255
//   inp_valid    inp carries a valid bit this cycle
//   inp          serial data bit
//   busy         high while scanning
//   done         one-cycle scan-complete pulse
//   det          one-cycle match pulse, the cycle after the matching bit
//   match_cnt    saturating match count of the current or last scan
//   found        at least one match occurred in the scan
//   first_pos    0-based index of the bit that completed the first match
module pattern_scan_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [7:0] cfg_pattern,
    input  logic [2:0] cfg_len,
    input  logic       cfg_overlap,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic       inp_valid,
    input  logic       inp,
    output logic       busy,
    output logic       done,
    output logic       det,
    output logic [7:0] match_cnt,
    output logic       found,
    output logic [7:0] first_pos
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned FILL_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [DATA_W-1:0]   pat_q, pat_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic                ov_q, ov_n;
    logic [DATA_W-1:0]   flen_q, flen_n;
    logic [DATA_W-1:0]   idx_q, idx_n;
    logic [DATA_W-1:0]   hist_q, hist_n;
    logic [FILL_W-1:0]   fill_q, fill_n;
    logic [DATA_W-1:0]   cnt_n;
    logic                found_n;
    logic [DATA_W-1:0]   first_n;
    logic                det_n;

    // Candidate history/fill after shifting in the current bit, and match test.
    logic [DATA_W-1:0]   hist_sh;
    logic [FILL_W-1:0]   fill_sh;
    logic [DATA_W-1:0]   len_mask;
    logic                hit;

    always_comb begin
        hist_sh  = {hist_q[DATA_W-2:0], inp};
        fill_sh  = (fill_q == FILL_W'(DATA_W)) ? fill_q : fill_q + FILL_W'(1);
        len_mask = DATA_W'(8'hFF) >> (LEN_W'(7) - len_q);
        // fill >= L is the same as fill > cfg_len
        hit      = (fill_sh > FILL_W'(len_q)) &&
                   (((hist_sh ^ pat_q) & len_mask) == '0);
    end

    // Next-state and datapath update.
    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        len_n   = len_q;
        ov_n    = ov_q;
        flen_n  = flen_q;
        idx_n   = idx_q;
        hist_n  = hist_q;
        fill_n  = fill_q;
        cnt_n   = match_cnt;
        found_n = found;
        first_n = first_pos;
        det_n   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    pat_n = cfg_pattern;
                    len_n = cfg_len;
                    ov_n  = cfg_overlap;
                end
                if (start) begin
                    flen_n  = frame_len;
                    cnt_n   = '0;
                    found_n = 1'b0;
                    first_n = '0;
                    idx_n   = '0;
                    hist_n  = '0;
                    fill_n  = '0;
                    state_n = (frame_len != '0) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                if (inp_valid) begin
                    hist_n = hist_sh;
                    fill_n = fill_sh;
                    idx_n  = idx_q + DATA_W'(1);
                    if (hit) begin
                        det_n = 1'b1;
                        cnt_n = (match_cnt == DATA_W'(8'hFF)) ? match_cnt
                                                              : match_cnt + DATA_W'(1);
                        if (!found) begin
                            found_n = 1'b1;
                            first_n = idx_q;
                        end
                        // Non-overlapping: matched bits may not seed the next match.
                        if (!ov_q) begin
                            fill_n = '0;
                        end
                    end
                    if (idx_q + DATA_W'(1) == flen_q) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ov_q      <= 1'b1;
            flen_q    <= '0;
            idx_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_cnt <= '0;
            found     <= 1'b0;
            first_pos <= '0;
            det       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            pat_q     <= pat_n;
            len_q     <= len_n;
            ov_q      <= ov_n;
            flen_q    <= flen_n;
            idx_q     <= idx_n;
            hist_q    <= hist_n;
            fill_q    <= fill_n;
            match_cnt <= cnt_n;
            found     <= found_n;
            first_pos <= first_n;
            det       <= det_n;
            busy      <= (state_n == S_SCAN);
            done      <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl: table-driven scans plus reset sequences.
module tb_pattern_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       start;
    logic [7:0] frame_len;
    logic       inp_valid;
    logic       inp;
    logic       busy;
    logic       done;
    logic       det;
    logic [7:0] match_cnt;
    logic       found;
    logic [7:0] first_pos;

    int n_tests = 0;
    int n_fail  = 0;

    pattern_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .frame_len   (frame_len),
        .inp_valid   (inp_valid),
        .inp         (inp),
        .busy        (busy),
        .done        (done),
        .det         (det),
        .match_cnt   (match_cnt),
        .found       (found),
        .first_pos   (first_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pat;
        logic [2:0]  len;
        logic        ov;
        logic [7:0]  flen;
        logic [15:0] bits;      // bits[i] is the i-th serial bit
        logic [15:0] det_mask;  // det_mask[i] set when bit i completes a match
        int          gap;       // idle cycles before each bit
        int          inject;    // bit index before which cfg_we/start are pulsed, -1 none
        logic [7:0]  exp_cnt;
        logic        exp_found;
        logic [7:0]  exp_first;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " det"}, int'(det), 0);
        check({tag, " match_cnt"}, int'(match_cnt), 0);
        check({tag, " found"}, int'(found), 0);
        check({tag, " first_pos"}, int'(first_pos), 0);
    endtask

    task automatic run_vec(input vec_t v, input int vi, input bit do_cfg);
        string t;
        t = $sformatf("v%0d", vi);
        if (do_cfg) begin
            cfg_we      = 1'b1;
            cfg_pattern = v.pat;
            cfg_len     = v.len;
            cfg_overlap = v.ov;
            step();
            cfg_we = 1'b0;
        end
        start     = 1'b1;
        frame_len = v.flen;
        step();
        start = 1'b0;
        if (v.flen == 8'd0) begin
            check({t, " empty done"}, int'(done), 1);
            check({t, " empty busy"}, int'(busy), 0);
        end else begin
            check({t, " busy after start"}, int'(busy), 1);
        end
        for (int i = 0; i < int'(v.flen); i++) begin
            if (i == v.inject) begin
                cfg_we      = 1'b1;
                cfg_pattern = 8'hFF;
                cfg_len     = 3'd7;
                cfg_overlap = 1'b0;
                start       = 1'b1;
                frame_len   = 8'd3;
                step();
                cfg_we = 1'b0;
                start  = 1'b0;
                check({t, " inject busy"}, int'(busy), 1);
                check({t, " inject det"}, int'(det), 0);
            end
            for (int g = 0; g < v.gap; g++) begin
                inp_valid = 1'b0;
                inp       = 1'b1;
                step();
                check($sformatf("%s stall%0d det", t, i), int'(det), 0);
                check($sformatf("%s stall%0d busy", t, i), int'(busy), 1);
            end
            inp_valid = 1'b1;
            inp       = v.bits[i];
            step();
            inp_valid = 1'b0;
            check($sformatf("%s det idx%0d", t, i), int'(det), int'(v.det_mask[i]));
            check($sformatf("%s done idx%0d", t, i), int'(done), (i == int'(v.flen) - 1) ? 1 : 0);
            check($sformatf("%s busy idx%0d", t, i), int'(busy), (i == int'(v.flen) - 1) ? 0 : 1);
        end
        check({t, " match_cnt"}, int'(match_cnt), int'(v.exp_cnt));
        check({t, " found"}, int'(found), int'(v.exp_found));
        check({t, " first_pos"}, int'(first_pos), int'(v.exp_first));
        step();
        check({t, " idle done"}, int'(done), 0);
        check({t, " idle busy"}, int'(busy), 0);
        check({t, " hold match_cnt"}, int'(match_cnt), int'(v.exp_cnt));
        check({t, " hold first_pos"}, int'(first_pos), int'(v.exp_first));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rv;
        //           pat    len   ov    flen   bits      det_mask gap inj cnt found first
        vecs[0] = '{8'h05, 3'd2, 1'b1, 8'd7,  16'h0035, 16'h0014, 0, -1, 8'd2, 1'b1, 8'd2};
        vecs[1] = '{8'h05, 3'd2, 1'b0, 8'd7,  16'h0035, 16'h0004, 0, -1, 8'd1, 1'b1, 8'd2};
        vecs[2] = '{8'h05, 3'd2, 1'b1, 8'd7,  16'h0035, 16'h0014, 3, -1, 8'd2, 1'b1, 8'd2};
        vecs[3] = '{8'h05, 3'd2, 1'b1, 8'd0,  16'h0000, 16'h0000, 0, -1, 8'd0, 1'b0, 8'd0};
        vecs[4] = '{8'h05, 3'd2, 1'b1, 8'd7,  16'h0035, 16'h0014, 0,  3, 8'd2, 1'b1, 8'd2};
        vecs[5] = '{8'hFF, 3'd7, 1'b1, 8'd10, 16'h03FF, 16'h0380, 0, -1, 8'd3, 1'b1, 8'd7};
        vecs[6] = '{8'h01, 3'd0, 1'b0, 8'd4,  16'h000D, 16'h000D, 0, -1, 8'd3, 1'b1, 8'd0};
        vecs[7] = '{8'h03, 3'd1, 1'b0, 8'd4,  16'h000F, 16'h000A, 0, -1, 8'd2, 1'b1, 8'd1};
        vecs[8] = '{8'h03, 3'd1, 1'b1, 8'd4,  16'h000F, 16'h000E, 0, -1, 8'd3, 1'b1, 8'd1};
        vecs[9] = '{8'h05, 3'd2, 1'b1, 8'd5,  16'h0000, 16'h0000, 0, -1, 8'd0, 1'b0, 8'd0};

        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 3'd0;
        cfg_overlap = 1'b0;
        start       = 1'b0;
        frame_len   = 8'd0;
        inp_valid   = 1'b0;
        inp         = 1'b0;
        step();
        step();
        check_idle_zero("reset");
        rst = 1'b0;
        step();

        for (int v = 0; v < NVEC; v++) begin
            run_vec(vecs[v], v, 1'b1);
        end

        // Reset during a scan, after four accepted bits (1,0,1,0).
        cfg_we = 1'b1; cfg_pattern = 8'h05; cfg_len = 3'd2; cfg_overlap = 1'b1;
        step();
        cfg_we = 1'b0;
        start = 1'b1; frame_len = 8'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inp_valid = 1'b1;
            inp       = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        inp_valid = 1'b0;
        check("midscan found before rst", int'(found), 1);
        rst = 1'b1;
        step();
        check_idle_zero("midscan rst");
        rst = 1'b0;
        step();

        // Post-reset config defaults: pattern 0, L=1, overlapping; bits 0,1,0.
        rv = '{8'h00, 3'd0, 1'b1, 8'd3, 16'h0002, 16'h0005, 0, -1, 8'd2, 1'b1, 8'd0};
        run_vec(rv, 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
